// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared widths and fragment type for the rasterizer depth-fetch stage
package raster_pkg;

  localparam int RASTER_ADDR_W          = 26;
  localparam int RASTER_COLOR_W         = 24;
  localparam int RASTER_DEPTH_W         = 32;
  localparam int RASTER_DATA_W          = 32;
  localparam int RASTER_MAX_OUTSTANDING = 8;
  localparam int RASTER_DEPTH_OFFSET    = 4;

  typedef struct packed {
    logic [RASTER_ADDR_W-1:0]  addr;
    logic [RASTER_COLOR_W-1:0] color;
    logic [RASTER_DEPTH_W-1:0] depth;
  } raster_frag_t;

endpackage

// File: rtl/rasterizer_depth_fetch_pipe_if.sv
// rtl/rasterizer_depth_fetch_pipe_if.sv - fragment, memory-master and result signals of the depth-fetch stage
interface rasterizer_depth_fetch_pipe_if
  import raster_pkg::*;
#(
  parameter int ADDR_W  = RASTER_ADDR_W,
  parameter int COLOR_W = RASTER_COLOR_W,
  parameter int DEPTH_W = RASTER_DEPTH_W,
  parameter int DATA_W  = RASTER_DATA_W
);

  logic                  input_valid;
  logic [ADDR_W-1:0]     addr_in;
  logic [COLOR_W-1:0]    color_in;
  logic [DEPTH_W-1:0]    depth_in;
  logic                  wait_request;

  logic [ADDR_W-1:0]     master_address;
  logic                  master_read;
  logic                  master_write;
  logic [DATA_W/8-1:0]   master_byteenable;
  logic [DATA_W-1:0]     master_writedata;
  logic                  master_waitrequest;
  logic [DATA_W-1:0]     master_readdata;
  logic                  master_readdatavalid;

  logic                  output_valid;
  logic                  output_ready;
  logic [ADDR_W-1:0]     addr_out;
  logic [COLOR_W-1:0]    color_out;
  logic [DEPTH_W-1:0]    new_depth_out;
  logic [DEPTH_W-1:0]    old_depth_out;
  logic                  underflow_err;

  // The depth-fetch stage itself
  modport master (
    input  input_valid, addr_in, color_in, depth_in,
    output wait_request,
    output master_address, master_read, master_write, master_byteenable, master_writedata,
    input  master_waitrequest, master_readdata, master_readdatavalid,
    output output_valid, addr_out, color_out, new_depth_out, old_depth_out, underflow_err,
    input  output_ready
  );

  // Fragment source, memory slave and result sink around the stage
  modport slave (
    output input_valid, addr_in, color_in, depth_in,
    input  wait_request,
    input  master_address, master_read, master_write, master_byteenable, master_writedata,
    output master_waitrequest, master_readdata, master_readdatavalid,
    input  output_valid, addr_out, color_out, new_depth_out, old_depth_out, underflow_err,
    output output_ready
  );

endinterface

// File: rtl/raster_sync_fifo.sv
// rtl/raster_sync_fifo.sv - registered synchronous FIFO with full/empty/count
module raster_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO is only taken when a pop frees the head slot in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; storage is cleared so heads read as zero after reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rasterizer_depth_fetch_pipe.sv
// rtl/rasterizer_depth_fetch_pipe.sv - depth-fetch stage; RASTER_DEPTH_TEST_EN enables in-stage depth culling
module rasterizer_depth_fetch_pipe
  import raster_pkg::*;
#(
  parameter int ADDR_W          = RASTER_ADDR_W,
  parameter int COLOR_W         = RASTER_COLOR_W,
  parameter int DEPTH_W         = RASTER_DEPTH_W,
  parameter int DATA_W          = RASTER_DATA_W,
  parameter int MAX_OUTSTANDING = RASTER_MAX_OUTSTANDING,
  parameter int DEPTH_OFFSET    = RASTER_DEPTH_OFFSET
) (
  input  logic                          clock,
  input  logic                          reset,
  rasterizer_depth_fetch_pipe_if.master bus
);

  localparam int META_W = ADDR_W + COLOR_W + DEPTH_W;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

  logic               cmd_valid;
  logic [ADDR_W-1:0]  cmd_addr;
  logic               wait_req;
  logic               accept;
  logic               cmd_retire;

  logic               meta_full;
  logic               meta_empty;
  logic [CNT_W-1:0]   meta_count;
  logic [META_W-1:0]  meta_head;

  logic               resp_full;
  logic               resp_empty;
  logic [CNT_W-1:0]   resp_count;
  logic [DEPTH_W-1:0] resp_head;

  logic               orphan_resp;
  logic               resp_push;
  logic               underflow_q;
  logic               pair_valid;
  logic               depth_fail;
  logic               pair_pop;

  // A stalled command blocks new fragments; a retiring one lets the next fragment in on the same cycle
  assign wait_req   = meta_full || (cmd_valid && bus.master_waitrequest);
  assign accept     = bus.input_valid && !wait_req;
  assign cmd_retire = cmd_valid && !bus.master_waitrequest;

  // Single-entry read command register, held while the slave stalls
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
    end else if (accept) begin
      cmd_valid <= 1'b1;
      cmd_addr  <= bus.addr_in + ADDR_W'(DEPTH_OFFSET);
    end else if (cmd_retire) begin
      cmd_valid <= 1'b0;
    end
  end

  raster_sync_fifo #(
    .WIDTH (META_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_meta_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data ({bus.addr_in, bus.color_in, bus.depth_in}),
    .pop       (pair_pop),
    .pop_data  (meta_head),
    .full      (meta_full),
    .empty     (meta_empty),
    .count     (meta_count)
  );

  // A response with every queued fragment already paired is stale (issued before a reset) and is dropped
  assign orphan_resp = bus.master_readdatavalid && (resp_count >= meta_count);
  assign resp_push   = bus.master_readdatavalid && !orphan_resp && !resp_full;

  raster_sync_fifo #(
    .WIDTH (DEPTH_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (resp_push),
    .push_data (bus.master_readdata[DEPTH_W-1:0]),
    .pop       (pair_pop),
    .pop_data  (resp_head),
    .full      (resp_full),
    .empty     (resp_empty),
    .count     (resp_count)
  );

  // Sticky record of any dropped stale response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underflow_q <= 1'b0;
    end else if (orphan_resp) begin
      underflow_q <= 1'b1;
    end
  end

  assign pair_valid = !meta_empty && !resp_empty;

`ifdef RASTER_DEPTH_TEST_EN
  // Fragments that are not strictly nearer than the stored depth are culled here
  assign depth_fail = pair_valid && (meta_head[DEPTH_W-1:0] >= resp_head);
`else
  assign depth_fail = 1'b0;
`endif

  // Culled pairs drain one per cycle without waiting on downstream
  assign pair_pop = pair_valid && (bus.output_ready || depth_fail);

  assign bus.wait_request      = wait_req;
  assign bus.master_address    = cmd_addr;
  assign bus.master_read       = cmd_valid;
  assign bus.master_write      = 1'b0;
  assign bus.master_byteenable = '1;
  assign bus.master_writedata  = '0;

  assign bus.output_valid  = pair_valid && !depth_fail;
  assign bus.addr_out      = meta_head[META_W-1 -: ADDR_W];
  assign bus.color_out     = meta_head[DEPTH_W +: COLOR_W];
  assign bus.new_depth_out = meta_head[DEPTH_W-1:0];
  assign bus.old_depth_out = resp_head;
  assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_rasterizer_depth_fetch_pipe.sv
// tb/tb_rasterizer_depth_fetch_pipe.sv - scoreboard bench for the depth-fetch stage
module tb_rasterizer_depth_fetch_pipe;
  import raster_pkg::*;

  localparam int AW = 26;
  localparam int CW = 24;
  localparam int DW = 32;
  localparam int BW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rasterizer_depth_fetch_pipe_if #(.ADDR_W(AW), .COLOR_W(CW), .DEPTH_W(DW), .DATA_W(BW)) bus ();

  rasterizer_depth_fetch_pipe #(
    .ADDR_W(AW), .COLOR_W(CW), .DEPTH_W(DW), .DATA_W(BW), .MAX_OUTSTANDING(8), .DEPTH_OFFSET(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    raster_frag_t frag;
    logic [31:0]  old;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rd_t;

  exp_t exp_q[$];
  rd_t  pend[$];
  logic [31:0] mem_over [logic [AW-1:0]];

  int vec_cnt = 0;
  int err_cnt = 0;
  int wr_mode = 0;
  int ready_mode = 0;
  int lat_lo = 2;
  int lat_hi = 2;
  int resp_hold = 0;
  int reads_issued = 0;

  function automatic logic [31:0] mem_lookup(logic [AW-1:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(string name, logic [127:0] got, logic [127:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: depth read goes to addr+4 mod 2^26; culling (when built in) drops new >= old
  function automatic void push_exp(logic [AW-1:0] a, logic [CW-1:0] c, logic [DW-1:0] d);
    exp_t e;
    logic [AW-1:0] ra;
    ra = a + AW'(4);
    e.frag.addr = a;
    e.frag.color = c;
    e.frag.depth = d;
    e.old = mem_lookup(ra);
`ifdef RASTER_DEPTH_TEST_EN
    if (d >= e.old) return;
`endif
    exp_q.push_back(e);
  endfunction

  // Memory slave: random or forced stalls, in-order responses after a latency, optional hold
  initial begin : slave
    int cyc;
    int last_due;
    int due;
    rd_t r;
    cyc = 0;
    last_due = 0;
    bus.master_waitrequest = 1'b0;
    bus.master_readdatavalid = 1'b0;
    bus.master_readdata = '0;
    forever begin
      @(negedge clock);
      cyc++;
      bus.master_readdatavalid = 1'b0;
      bus.master_readdata = $urandom;
      if (resp_hold == 0 && pend.size() > 0 && pend[0].due <= cyc) begin
        bus.master_readdatavalid = 1'b1;
        bus.master_readdata = mem_lookup(pend[0].addr);
        void'(pend.pop_front());
      end
      case (wr_mode)
        0:       bus.master_waitrequest = 1'b0;
        1:       bus.master_waitrequest = 1'b1;
        default: bus.master_waitrequest = ($urandom_range(2, 0) == 0);
      endcase
      #1;
      if (bus.master_read && !bus.master_waitrequest) begin
        reads_issued++;
        due = cyc + $urandom_range(lat_hi, lat_lo);
        if (due < last_due) due = last_due;
        last_due = due;
        r.addr = bus.master_address;
        r.due = due;
        pend.push_back(r);
      end
    end
  end

  // Monitor: compares each presented result with the scoreboard head and checks hold stability
  initial begin : monitor
    logic [127:0] got;
    logic [127:0] prev_got;
    logic         prev_hold;
    prev_hold = 1'b0;
    prev_got = '0;
    bus.output_ready = 1'b0;
    forever begin
      @(negedge clock);
      case (ready_mode)
        0:       bus.output_ready = 1'b1;
        1:       bus.output_ready = 1'b0;
        default: bus.output_ready = ($urandom_range(1, 0) == 1);
      endcase
      #2;
      got = {14'd0, bus.addr_out, bus.color_out, bus.new_depth_out, bus.old_depth_out};
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", 128'(bus.output_valid), 128'd1);
          check("hold_stable", got, prev_got);
        end
        if (bus.output_valid) begin
          if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_output: got %0h expected no output", got);
          end else begin
            check("output_fields", got,
                  {14'd0, exp_q[0].frag.addr, exp_q[0].frag.color, exp_q[0].frag.depth, exp_q[0].old});
            if (bus.output_ready) void'(exp_q.pop_front());
          end
        end
        prev_hold = bus.output_valid && !bus.output_ready;
        prev_got = got;
      end
    end
  end

  // Offer one fragment starting on a negedge; returns on the negedge after acceptance
  task automatic send(logic [AW-1:0] a, logic [CW-1:0] c, logic [DW-1:0] d);
    int budget;
    budget = 300;
    bus.input_valid = 1'b1;
    bus.addr_in = a;
    bus.color_in = c;
    bus.depth_in = d;
    forever begin
      #1;
      if (!bus.wait_request) begin
        push_exp(a, c, d);
        @(negedge clock);
        bus.input_valid = 1'b0;
        return;
      end
      budget--;
      if (budget == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL accept_timeout: got wait_request=1 expected acceptance of addr %0h", a);
        @(negedge clock);
        bus.input_valid = 1'b0;
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_drain(string name, int budget);
    @(negedge clock);
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check(name, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.input_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int rb;
    logic [AW-1:0] ra;
    bus.input_valid = 1'b0;
    bus.addr_in = '0;
    bus.color_in = '0;
    bus.depth_in = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_wait_request", 128'(bus.wait_request), 128'd0);
    check("rst_master_read", 128'(bus.master_read), 128'd0);
    check("rst_master_address", 128'(bus.master_address), 128'd0);
    check("rst_output_valid", 128'(bus.output_valid), 128'd0);
    check("rst_underflow", 128'(bus.underflow_err), 128'd0);
    check("rst_out_fields", {bus.addr_out, bus.color_out, bus.new_depth_out, bus.old_depth_out}, 128'd0);
    check("tie_write", {bus.master_write, bus.master_writedata}, 128'd0);
    check("tie_byteenable", 128'(bus.master_byteenable), 128'hF);

    // Single fragment, slave answers after 3 cycles
    @(negedge clock);
    lat_lo = 3;
    lat_hi = 3;
    mem_over[26'h104] = 32'h80;
    send(26'h100, 24'hABCDEF, 32'h50);
    #1;
    check("t1_read_n1", 128'(bus.master_read), 128'd1);
    check("t1_addr_n1", 128'(bus.master_address), 128'h104);
    wait_drain("t1_drain", 50);

    // Address wrap modulo 2^26
    send(26'h3FF_FFFE, 24'h123456, 32'h1);
    #1;
    check("wrap_addr", 128'(bus.master_address), 128'h2);
    wait_drain("wrap_drain", 50);

    // Slave stalls the pending command for 4 cycles
    #3 wr_mode = 1;
    @(negedge clock);
    rb = reads_issued;
    send(26'h200, 24'h00FF00, 32'h7);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_read", 128'(bus.master_read), 128'd1);
      check("stall_addr", 128'(bus.master_address), 128'h204);
      check("stall_wait_request", 128'(bus.wait_request), 128'd1);
      @(negedge clock);
    end
    #3 wr_mode = 0;
    repeat (10) @(negedge clock);
    check("stall_one_read", 128'(reads_issued - rb), 128'd1);
    wait_drain("stall_drain", 50);

    // 20 fragments with responses withheld: only 8 reads may go out
    #3 resp_hold = 1;
    lat_lo = 1;
    lat_hi = 1;
    @(negedge clock);
    rb = reads_issued;
    fork
      begin
        for (int i = 0; i < 20; i++) send(AW'($urandom), CW'($urandom), $urandom);
      end
      begin
        repeat (40) @(negedge clock);
        #1;
        check("full_reads", 128'(reads_issued - rb), 128'd8);
        check("full_wait_request", 128'(bus.wait_request), 128'd1);
        #2 resp_hold = 0;
      end
    join
    wait_drain("full_drain", 300);

    // Downstream stalled while 8 responses come back
    #3 ready_mode = 1;
    lat_lo = 2;
    lat_hi = 2;
    @(negedge clock);
    for (int i = 0; i < 8; i++) send(AW'($urandom), CW'($urandom), $urandom);
    repeat (12) @(negedge clock);
    #1;
    if (exp_q.size() != 0) check("bp_valid", 128'(bus.output_valid), 128'd1);
    #2 ready_mode = 0;
    wait_drain("bp_drain", 100);

    // Reset with 3 reads in flight, then stale responses
    #3 resp_hold = 1;
    lat_lo = 1;
    lat_hi = 1;
    @(negedge clock);
    rb = reads_issued;
    for (int i = 0; i < 3; i++) send(26'h500 + AW'(i * 16), CW'(i), 32'h100);
    repeat (3) @(negedge clock);
    check("mid_reads", 128'(reads_issued - rb), 128'd3);
    do_reset();
    #1;
    check("mid_underflow_clr", 128'(bus.underflow_err), 128'd0);
    #2 resp_hold = 0;
    repeat (10) @(negedge clock);
    #1;
    check("stale_underflow", 128'(bus.underflow_err), 128'd1);
    check("stale_no_output", 128'(bus.output_valid), 128'd0);
    @(negedge clock);
    send(26'h600, 24'h0A0B0C, 32'h33);
    wait_drain("post_reset_drain", 50);
    check("underflow_sticky", 128'(bus.underflow_err), 128'd1);

    // Depth-test pair: near fragment kept, far fragment culled when the test is built in
    mem_over[26'h304] = 32'h20;
    mem_over[26'h404] = 32'h20;
    send(26'h300, 24'h111111, 32'h10);
    send(26'h400, 24'h222222, 32'h30);
    wait_drain("depth_pair_drain", 50);

    // Random traffic with random stalls, latencies and backpressure
    #3 wr_mode = 2;
    ready_mode = 2;
    lat_lo = 1;
    lat_hi = 6;
    @(negedge clock);
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(2, 0)) @(negedge clock);
      if ($urandom_range(7, 0) == 0) ra = 26'h3FF_FFFC + AW'($urandom_range(3, 0));
      else ra = AW'($urandom);
      send(ra, CW'($urandom), $urandom);
    end
    wait_drain("random_drain", 2000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
